// File: rtl/cplx_pkg.sv
// cplx_pkg: shared constants and helpers for the complex multiply-accumulate back end.
//   IN_W_DEF / OUT_W_DEF : default product and result widths
//   clog2                : ceiling log2, used to size accumulator growth
//   sat_round            : round-half-up, arithmetic shift and clamp of a signed sum
package cplx_pkg;

    localparam int unsigned IN_W_DEF  = 37;
    localparam int unsigned OUT_W_DEF = 16;

    // Working width of sat_round; callers sign-extend their sum to this width.
    // Wide enough for IN_W_DEF + 10 growth bits + 1 rounding bit with margin.
    localparam int unsigned SR_W = 64;

    typedef struct packed {
        logic                   sat;
        logic signed [SR_W-1:0] value;
    } sat_round_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = unsigned'(i + 1);
            end
        end
        return result;
    endfunction

    function automatic sat_round_t sat_round(input logic signed [SR_W-1:0] value,
                                             input int unsigned            shift,
                                             input int unsigned            out_w);
        logic signed [SR_W-1:0] one;
        logic signed [SR_W-1:0] rnd;
        logic signed [SR_W-1:0] q;
        logic signed [SR_W-1:0] max_v;
        logic signed [SR_W-1:0] min_v;
        sat_round_t             res;
        one = SR_W'(1);
        rnd = value;
        // Adding half an LSB before the floor shift gives round-half-up.
        if (shift > 0) begin
            rnd = value + (one <<< (shift - 1));
        end
        q     = rnd >>> shift;
        max_v = (one <<< (out_w - 1)) - one;
        min_v = -(one <<< (out_w - 1));
        res.sat   = 1'b0;
        res.value = q;
        if (q > max_v) begin
            res.value = max_v;
            res.sat   = 1'b1;
        end else if (q < min_v) begin
            res.value = min_v;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cplx_acc_lane.sv
// cplx_acc_lane: one signed accumulator with round/shift/saturate on dump.
//   clk, rst   : clock, asynchronous active-high reset
//   ce         : clock enable, all state holds when low
//   clr        : discard partial sum (highest priority)
//   add        : accumulate din into the partial sum
//   dump       : add din, round/saturate, register result, clear accumulator
//   din        : signed product input (IN_W)
//   dout       : registered signed result (OUT_W), holds between dumps
//   sat        : registered saturation flag of the last dump
module cplx_acc_lane
    import cplx_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned ACC_W = IN_W_DEF + 2,
    parameter int unsigned SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic             add,
    input  logic             dump,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W:0]   sum;
    sat_round_t              rs;
    logic [OUT_W-1:0]        dout_d;
    logic                    sat_d;
    logic                    unused_hi;

    // One extra bit so the dump-time sum and its rounding add never wrap.
    assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - IN_W){din[IN_W-1]}}, din};
    assign rs  = sat_round({{(SR_W - ACC_W - 1){sum[ACC_W]}}, sum}, SHIFT, OUT_W);

    // Clamped value fits OUT_W, so upper bits are pure sign copies.
    assign unused_hi = ^rs.value[SR_W-1:OUT_W];

    always_comb begin
        acc_d  = acc_q;
        dout_d = dout;
        sat_d  = sat;
        if (clr) begin
            acc_d = '0;
        end else if (dump) begin
            acc_d  = '0;
            dout_d = rs.value[OUT_W-1:0];
            sat_d  = rs.sat;
        end else if (add) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            dout  <= '0;
            sat   <= 1'b0;
        end else if (ce) begin
            acc_q <= acc_d;
            dout  <= dout_d;
            sat   <= sat_d;
        end
    end

endmodule

// File: rtl/cplx_acc_dump.sv
// cplx_acc_dump: complex integrate-and-dump over ACC_LEN valid products, with
// round-half-up, right shift by SHIFT and saturation to OUT_W per component.
//   clk, rst          : clock, asynchronous active-high reset
//   ce                : clock enable, all state (including out_valid) holds when low
//   clr               : synchronous abort of the partial sum, beats in_valid
//   in_valid          : real_in/imag_in carry a product to accumulate
//   real_in, imag_in  : signed products (IN_W)
//   out_valid         : single-cycle result pulse
//   real_out, imag_out: registered signed results (OUT_W), hold between pulses
//   sat               : either component clamped in the current result
//   busy              : partial sum in progress
module cplx_acc_dump
    import cplx_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int unsigned ACC_LEN = 4,
    parameter int unsigned SHIFT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  real_in,
    input  logic [IN_W-1:0]  imag_in,
    output logic             out_valid,
    output logic [OUT_W-1:0] real_out,
    output logic [OUT_W-1:0] imag_out,
    output logic             sat,
    output logic             busy
);

    localparam int unsigned CW    = clog2(ACC_LEN);
    localparam int unsigned ACC_W = IN_W + CW;
    // ACC_LEN=1 needs no counter bits; keep one so the register is legal.
    localparam int unsigned CNT_W = (CW > 0) ? CW : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             out_valid_d;
    logic             last;
    logic             add;
    logic             dump;
    logic             sat_r;
    logic             sat_i;

    assign last = (count_q == CNT_W'(ACC_LEN - 1));
    assign dump = in_valid & ~clr & last;
    assign add  = in_valid & ~clr & ~last;
    assign busy = (count_q != '0);
    assign sat  = sat_r | sat_i;

    always_comb begin
        count_d     = count_q;
        out_valid_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (dump) begin
            count_d     = '0;
            out_valid_d = 1'b1;
        end else if (add) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            count_q   <= count_d;
            out_valid <= out_valid_d;
        end
    end

    cplx_acc_lane #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_lane_real (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .clr  (clr),
        .add  (add),
        .dump (dump),
        .din  (real_in),
        .dout (real_out),
        .sat  (sat_r)
    );

    cplx_acc_lane #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_lane_imag (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .clr  (clr),
        .add  (add),
        .dump (dump),
        .din  (imag_in),
        .dout (imag_out),
        .sat  (sat_i)
    );

endmodule

// File: tb/tb_cplx_acc_dump.sv
// tb_cplx_acc_dump: directed plus randomized checks of cplx_acc_dump against a
// block-sum reference model (sum ACC_LEN samples, floor((sum + half) / 2^SHIFT), clamp).
module tb_cplx_acc_dump;

    localparam int unsigned IN_W    = 37;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned ACC_LEN = 4;
    localparam int unsigned SHIFT   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             clr;
    logic             in_valid;
    logic [IN_W-1:0]  real_in;
    logic [IN_W-1:0]  imag_in;
    logic             out_valid;
    logic [OUT_W-1:0] real_out;
    logic [OUT_W-1:0] imag_out;
    logic             sat;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    longint           m_sum_r;
    longint           m_sum_i;
    int               m_cnt;
    logic             m_valid;
    logic [OUT_W-1:0] m_r;
    logic [OUT_W-1:0] m_i;
    logic             m_sat;

    always #5 clk = ~clk;

    cplx_acc_dump #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .ACC_LEN (ACC_LEN),
        .SHIFT   (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .clr       (clr),
        .in_valid  (in_valid),
        .real_in   (real_in),
        .imag_in   (imag_in),
        .out_valid (out_valid),
        .real_out  (real_out),
        .imag_out  (imag_out),
        .sat       (sat),
        .busy      (busy)
    );

    function automatic longint ref_scale(input longint s, output logic clamped);
        longint div;
        longint num;
        longint q;
        longint hi;
        longint lo;
        div = longint'(1) << SHIFT;
        num = s + div / 2;
        if (num >= 0) q = num / div;
        else q = -((-num + div - 1) / div);
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        clamped = 1'b0;
        if (q > hi) begin
            q = hi;
            clamped = 1'b1;
        end else if (q < lo) begin
            q = lo;
            clamped = 1'b1;
        end
        return q;
    endfunction

    function automatic longint rand_in();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 4000)) - 2000;
            1: v = longint'($urandom_range(0, 200000)) - 100000;
            2: begin
                v = {$urandom, $urandom};
                v = (v <<< 27) >>> 27;
            end
            default: v = ($urandom_range(0, 1) != 0) ? (longint'(1) <<< 36) - 1
                                                     : -(longint'(1) <<< 36);
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_sum_r = 0;
        m_sum_i = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_r     = '0;
        m_i     = '0;
        m_sat   = 1'b0;
    endtask

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
        check({tag, ".busy"}, {63'd0, busy}, {63'd0, (m_cnt != 0)});
        check({tag, ".real_out"}, 64'($signed(real_out)), 64'($signed(m_r)));
        check({tag, ".imag_out"}, 64'($signed(imag_out)), 64'($signed(m_i)));
        check({tag, ".sat"}, {63'd0, sat}, {63'd0, m_sat});
    endtask

    // Drive one cycle, advance the model across the same edge, then compare.
    task automatic step(input logic c, input logic cl, input logic v, input longint r,
                        input longint i, input string tag);
        logic sr;
        logic si;
        ce       = c;
        clr      = cl;
        in_valid = v;
        real_in  = r[IN_W-1:0];
        imag_in  = i[IN_W-1:0];
        @(posedge clk);
        if (c) begin
            if (cl) begin
                m_sum_r = 0;
                m_sum_i = 0;
                m_cnt   = 0;
                m_valid = 1'b0;
            end else if (v) begin
                m_sum_r += r;
                m_sum_i += i;
                m_cnt++;
                m_valid = 1'b0;
                if (m_cnt == int'(ACC_LEN)) begin
                    m_r     = OUT_W'(ref_scale(m_sum_r, sr));
                    m_i     = OUT_W'(ref_scale(m_sum_i, si));
                    m_sat   = sr | si;
                    m_valid = 1'b1;
                    m_sum_r = 0;
                    m_sum_i = 0;
                    m_cnt   = 0;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 0, 0, tag);
    endtask

    initial begin
        longint big;
        big      = longint'(1) <<< 34;
        rst      = 1'b1;
        ce       = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        real_in  = '0;
        imag_in  = '0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Basic block: 12 -> 3, -20 -> -5
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 3, -5, "basic");
        idle(2, "basic_after");

        // Saturation both ways
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, big, -big, "sat");
        idle(1, "sat_after");

        // Gaps, a ce stall mid-block (in_valid ignored), and a stall over the pulse
        step(1'b1, 1'b0, 1'b1, big, -big, "gap");
        step(1'b1, 1'b0, 1'b1, big, -big, "gap");
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 999, 999, "gap_ce0");
        idle(3, "gap_idle");
        step(1'b1, 1'b0, 1'b1, big, -big, "gap");
        idle(1, "gap_idle");
        step(1'b1, 1'b0, 1'b1, big, -big, "gap_dump");
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 0, 0, "hold_ce0");
        idle(1, "hold_after");

        // Continuous stream: pulses every ACC_LEN samples
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b1, 1, 0, "stream");
        idle(1, "stream_after");

        // clr drops partial sum and the coincident sample
        step(1'b1, 1'b0, 1'b1, 100, 100, "clr_pre");
        step(1'b1, 1'b0, 1'b1, 100, 100, "clr_pre");
        step(1'b1, 1'b1, 1'b1, 100, 100, "clr");
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 1, -1, "clr_post");
        idle(1, "clr_after");

        // Asynchronous reset between edges mid-block
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 50, 50, "arst_pre");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 7, -7, "arst_post");
        idle(1, "arst_after");

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7), rand_in(), rand_in(), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cplx_acc_dump.md
Name: cplx_acc_dump

Overview:
- Downstream consumer of the complex multiplier outputs (realo/imago, IN_W bits, signed).
- Integrate-and-dump stage: sums ACC_LEN valid complex products, then rounds and right-shifts by SHIFT.
- Saturates the result to OUT_W bits and emits one registered result with a single-cycle valid pulse.
- Feeds the correlator/filter back end, giving a multiplier-plus-accumulator chain usable as a complex MAC.

Parameters:
- IN_W, 37: input width; equals 2*18+1, matching the 18-bit multiplier product.
- OUT_W, 16: output width per component, signed.
- ACC_LEN, 4: products summed per dump; legal range 1..1024.
- SHIFT, 2: right shift applied after accumulation; legal range 0..IN_W+10.
- CW, derived as clog2(ACC_LEN): accumulator growth bits. ACC_W = IN_W + CW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ce  in  1  clock enable; when low, all state holds
- clr  in  1  synchronous abort: discards the partial sum; has priority over in_valid
- in_valid  in  1  current real_in/imag_in are a product to accumulate
- real_in  in  IN_W  signed real product
- imag_in  in  IN_W  signed imaginary product
- out_valid  out  1  one-cycle pulse: a result is present
- real_out  out  OUT_W  signed rounded/saturated real sum
- imag_out  out  OUT_W  signed rounded/saturated imaginary sum
- sat  out  1  set when either component saturated in the current result; qualified by out_valid
- busy  out  1  partial sum in progress (count != 0)

Behaviour:
Reset (rst=1, asynchronous):
- All outputs, both accumulators and the count go to 0 immediately.
- Reset mid-accumulation discards the partial sum; no out_valid is produced.
- The first sample after reset release starts a fresh accumulation.

Gating and priority:
- All updates occur on rising clk only when ce=1.
- With ce=0, every register holds, including out_valid. Downstream consumers must qualify out_valid with ce.
- Priority at each enabled edge: clr, then in_valid, then idle.

Accumulation:
- clr=1: accumulators and count go to 0; out_valid goes to 0.
- in_valid=1 and count < ACC_LEN-1:
  - acc_r <= acc_r + sext(real_in); acc_i <= acc_i + sext(imag_in); count++.
  - out_valid <= 0.
- in_valid=1 and count == ACC_LEN-1 (dump):
  - sum = acc + sext(input) at ACC_W+1 bits.
  - rnd = sum + 2^(SHIFT-1) when SHIFT>0; no rounding add when SHIFT=0.
  - q = rnd >>> SHIFT (arithmetic). This is round-half-up: -4.5 -> -4, 4.5 -> 5.
  - Clamp q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the clamped real_out/imag_out; out_valid <= 1.
  - sat <= (real clamped) | (imag clamped).
  - Accumulators and count go to 0 on the same edge.
- in_valid=0: accumulators hold; out_valid <= 0. Gaps between samples are allowed at any position.

Timing and holds:
- Latency: result is registered one clk after the edge accepting the ACC_LEN-th sample.
- Back-to-back: a sample arriving on the cycle after a dump is the first sample of the next block. Throughput is one sample per clk.
- real_out, imag_out and sat hold their last value between pulses.
- ACC_LEN=1: every valid sample dumps directly and count stays 0.

Width rule:
- Accumulator width ACC_W ensures no internal overflow for ACC_LEN full-scale inputs.
- The rounding add uses one extra bit, so it cannot overflow.

Decomposition:
- Shared package cplx_pkg holds:
  - localparams IN_W_DEF=37 and OUT_W_DEF=16;
  - a function clog2;
  - a function sat_round(value, SHIFT, OUT_W) returning the clamped value and a saturation bit.
- Sub-module cplx_acc_lane: one signed accumulator plus round/saturate path, instantiated twice (real and imaginary).
- Shared count and control logic live in the top level.

Test Plan:
- Reset, then 4 samples with real_in=3, imag_in=-5 (defaults) -> one cycle later out_valid=1 for exactly 1 cycle, real_out=3 (14>>2), imag_out=-5 (-18>>2), sat=0.
- 4 samples with real_in=2^34, imag_in=-2^34 -> real_out=32767, imag_out=-32768, sat=1.
- Same 4 samples with in_valid=0 gaps of 0, 3 and 1 cycles between them, plus ce=0 for 5 cycles mid-block -> result identical to the gapless case. out_valid stays high throughout the ce=0 stall if it coincides with one.
- Continuous in_valid for 12 cycles with real_in=1 -> out_valid on cycles 5, 9 and 13 (counting the first accepted sample as cycle 1), real_out=1 each time ((4+2)>>2), busy=0 after each dump.
- 2 samples of real_in=100, then clr=1 together with in_valid=1, then 4 samples of 1 -> single result real_out=1. The clr-cycle sample and the partial sum are dropped.
- 3 samples, then assert rst asynchronously between edges -> outputs 0 immediately, no out_valid. Next 4 samples of 7 -> real_out=7 ((28+2)>>2).
